// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch / count-down timer controller with a lap-capture FIFO.
// Buttons are edge-detected internally; the FIFO is drained over valid/ready.
module stopwatch_lap_ctrl #(
    parameter int CNT_W      = 24,
    parameter int LAP_DEPTH  = 4,
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         reset,
    input  logic                         lap,
    input  logic [CNT_W-1:0]             load_val,
    output logic                         enable,
    output logic [1:0]                   status,
    output logic [CNT_W-1:0]             count,
    output logic                         expired,
    output logic                         lap_valid,
    output logic [CNT_W-1:0]             lap_data,
    input  logic                         lap_ready,
    output logic [$clog2(LAP_DEPTH):0]   lap_level,
    output logic                         lap_overflow
);

    localparam int AW = $clog2(LAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    state_t state;

    logic start_q;
    logic stop_q;
    logic reset_q;
    logic lap_q;

    logic ev_start;
    logic ev_stop;
    logic ev_reset;
    logic ev_lap;

    logic [CNT_W-1:0] idle_val;
    logic             lap_push;

    logic [CNT_W-1:0] mem [LAP_DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             pop;
    logic             push;

    // One register per button so a held press yields a single event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            reset_q <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            reset_q <= reset;
            lap_q   <= lap;
        end
    end

    assign ev_start = start & ~start_q;
    assign ev_stop  = stop  & ~stop_q;
    assign ev_reset = reset & ~reset_q;
    assign ev_lap   = lap   & ~lap_q;

    assign idle_val = COUNT_DOWN ? load_val : '0;

    // Lap only counts when no higher-priority button fired this cycle
    assign lap_push = ev_lap & ~ev_reset & ~ev_stop & ~ev_start
                    & (state != IDLE);

    assign status = state;
    assign enable = (state == RUNNING);

    // Control FSM with the elapsed-time counter and expiry pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (ev_reset) begin
                state <= IDLE;
                count <= idle_val;
            end else begin
                case (state)
                    IDLE: begin
                        count <= idle_val;
                        if (!ev_stop && ev_start) begin
                            if (COUNT_DOWN && load_val == '0) begin
                                state   <= EXPIRED;
                                expired <= 1'b1;
                            end else begin
                                state <= RUNNING;
                            end
                        end
                    end
                    RUNNING: begin
                        if (tick) begin
                            if (COUNT_DOWN)
                                count <= count - 1'b1;
                            else
                                count <= count + 1'b1;
                        end
                        if (ev_stop) begin
                            state <= PAUSED;
                        end else if (COUNT_DOWN && tick
                                     && count == CNT_W'(1)) begin
                            state   <= EXPIRED;
                            expired <= 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (!ev_stop && ev_start)
                            state <= RUNNING;
                    end
                    EXPIRED: begin
                        state <= EXPIRED;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign lap_valid = (lap_level != '0);
    assign full      = (lap_level == (AW+1)'(LAP_DEPTH));
    assign pop       = lap_valid & lap_ready;
    assign push      = lap_push & (~full | pop);
    assign lap_data  = mem[rd_ptr];

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            lap_level    <= '0;
            lap_overflow <= 1'b0;
        end else if (ev_reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            lap_level    <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   lap_level <= lap_level + 1'b1;
                2'b01:   lap_level <= lap_level - 1'b1;
                default: lap_level <= lap_level;
            endcase
            if (lap_push && full && !pop)
                lap_overflow <= 1'b1;
        end
    end

    // Lap storage captures the count as it stood before this cycle's tick
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= count;
    end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Parametrised next-generation stopwatch controller. It combines the run/pause control FSM with the elapsed-time counter, an optional count-down (timer) mode with expiry, and a lap-capture FIFO that software or the display path drains over a valid/ready interface. It sits between the button front-end and the display/readout logic, and is driven by a one-cycle base-rate tick.

Parameters:
CNT_W, 24, width of the tick counter and of each lap entry
LAP_DEPTH, 4, number of lap entries held (power of 2, >=2)
COUNT_DOWN, 0, 0 = count-up stopwatch, 1 = count-down timer with expiry

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
tick  in  1  one-cycle pulse at the counting rate
start  in  1  start/resume button (synchronous level)
stop  in  1  pause button (synchronous level)
reset  in  1  user reset button (synchronous level)
lap  in  1  lap-capture button (synchronous level)
load_val  in  CNT_W  count-down preset, sampled while IDLE
enable  out  1  high iff state is RUNNING
status  out  2  00 = IDLE, 01 = RUNNING, 10 = PAUSED, 11 = EXPIRED
count  out  CNT_W  current counter value (registered)
expired  out  1  one-cycle pulse on entry to EXPIRED
lap_valid  out  1  FIFO not empty
lap_data  out  CNT_W  FIFO head entry, valid when lap_valid is high
lap_ready  in  1  consumer pop; a pop occurs when lap_valid and lap_ready are both high
lap_level  out  $clog2(LAP_DEPTH)+1  number of entries held
lap_overflow  out  1  sticky flag: a lap was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low): state IDLE, count = 0, all button edge registers = 0, FIFO empty. Outputs: lap_valid = 0, lap_level = 0, lap_overflow = 0, expired = 0, enable = 0, status = 00.
- Button edge detection:
  - Each button is registered once internally (btn_q); an event is btn & ~btn_q.
  - A held button produces exactly one event.
  - A state change is visible one cycle after the cycle in which the button is first high.
- Event priority within one cycle: reset > stop > start > lap.
- Transitions:
  - IDLE: start -> RUNNING. In COUNT_DOWN mode, start with load_val == 0 -> EXPIRED instead.
  - RUNNING: stop -> PAUSED. In COUNT_DOWN mode, tick with count == 1 -> EXPIRED.
  - PAUSED: start -> RUNNING.
  - EXPIRED: only reset leaves it; start and stop are ignored.
  - A reset event from any state -> IDLE.
  - An illegal state encoding -> IDLE.
- Counter:
  - IDLE, count-up mode: count = 0.
  - IDLE, count-down mode: count = load_val, reloaded every cycle.
  - RUNNING with tick, count-up: count + 1, wrapping from 2^CNT_W-1 to 0 with no flag.
  - RUNNING with tick, count-down: count - 1.
  - PAUSED and EXPIRED: count holds.
- Same-cycle events:
  - tick together with stop in RUNNING: the tick is counted, then the state goes to PAUSED.
  - tick together with start in PAUSED: the tick is not counted.
  - tick together with a reset event: the reset wins.
- expired asserts for exactly the one cycle after the transition into EXPIRED.
- Lap capture:
  - A lap event in RUNNING, PAUSED or EXPIRED pushes the pre-update count value (value before this cycle's tick).
  - A lap event in IDLE is ignored.
  - A lap event is ignored if a higher-priority event fires in the same cycle.
- FIFO:
  - First-in first-out, LAP_DEPTH entries, lap_data driven from registers.
  - A push when full is accepted only if a pop occurs in the same cycle. Otherwise the entry is dropped and lap_overflow is set.
  - A pop when empty has no effect.
  - Push and pop in the same cycle leave lap_level unchanged.
  - A reset event empties the FIFO and clears lap_overflow.
  - Pops are independent of FSM state.
- status is a direct function of the state register; enable = (state == RUNNING).

Test Plan:
- Count-up basic: reset, pulse start, then 10 ticks, then stop, then 3 ticks -> status 01 then 10, count = 10 and holds at 10; start again plus 5 ticks -> count = 15.
- Held button and priority: hold start high for 8 cycles -> exactly one IDLE->RUNNING transition; assert stop and start in the same cycle while RUNNING -> PAUSED; assert reset with stop and start -> IDLE, count = 0.
- Count-down expiry (COUNT_DOWN=1): load_val = 3, start, then 3 ticks -> count 2, 1, 0; status 11 with a one-cycle expired pulse; further ticks and start are ignored; reset -> IDLE with count = 3.
- Lap FIFO fill and overflow (LAP_DEPTH=4, lap_ready = 0): 5 lap events at counts 2, 4, 6, 8, 10 -> lap_level = 4, lap_overflow = 1; draining yields 2, 4, 6, 8 in order, then lap_valid = 0.
- Full-FIFO push with simultaneous pop: with the FIFO full, a lap event and a pop in the same cycle -> the entry is accepted, lap_level stays 4, lap_overflow stays 0; a lap event in IDLE -> no push.
- Tick boundary cases: tick with stop in the same cycle -> count increments by 1; tick with start from PAUSED -> no increment; count-up wrap with CNT_W=4 -> after 16 ticks count = 0.
